// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter with sequential, branch and register-jump selection,
// stall/halt control and sticky misaligned-redirect detection.
module pc_update_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        branch_taken,
   input  logic [31:0] br_offset,
   input  logic        jump_reg,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        halted,
   output logic        align_err,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {RUN, STALLED, HALTED} state_t;
   state_t state, state_nx;
   logic adv, redirect, fault, load;
   logic [31:0] target, pc_nx;
   assign pc_plus4 = pc + 32'(PC_STEP);
   assign halted   = state == HALTED;
   always_comb begin
      adv      = !halted && en && !stall && !halt_req;
      redirect = jump_reg || branch_taken;
      target   = jump_reg ? reg_target : pc_plus4 + br_offset;
      fault    = adv && redirect && (target[1:0] != 2'b00);
      load     = adv && !fault;
      pc_nx    = load ? (redirect ? target : pc_plus4) : pc;
      // halt_req outranks stall, so a halt is honoured even while stalled
      state_nx = (halted || halt_req || fault) ? HALTED : (stall || !en) ? STALLED : RUN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         align_err   <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         instr_valid <= state_nx != HALTED;
         align_err   <= align_err || fault;
         fetch_count <= fetch_count + {31'd0, load};
      end
   end
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed scenarios for pc_update_unit with hand-computed expectations.
module tb_pc_update_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        stall = 1'b0;
   logic        halt_req = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] br_offset = '0;
   logic        jump_reg = 1'b0;
   logic [31:0] reg_target = '0;
   logic [31:0] pc, pc_plus4, fetch_count;
   logic        instr_valid, halted, align_err;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_fc = '0;

   pc_update_unit dut (
      .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .halt_req(halt_req),
      .branch_taken(branch_taken), .br_offset(br_offset), .jump_reg(jump_reg),
      .reg_target(reg_target), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
      .halted(halted), .align_err(align_err), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic jump_to(input logic [31:0] a);
      jump_reg = 1'b1;
      reg_target = a;
      step();
      jump_reg = 1'b0;
      exp_fc = exp_fc + 1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b1; stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0; jump_reg = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_fc = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if (pc !== 32'h0 || instr_valid !== 1'b0 || halted !== 1'b0 || align_err !== 1'b0 || fetch_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: got pc=%h v=%b h=%b a=%b fc=%h expected pc=0 v=0 h=0 a=0 fc=0", pc, instr_valid, halted, align_err, fetch_count);
      end
      n_checks++;
      if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4); end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      exp_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_pc = exp_pc + 32'h4;
         exp_fc = exp_fc + 1;
         n_checks++;
         if (pc !== exp_pc || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_step%0d: got pc=%h v=%b expected pc=%h v=1", i, pc, instr_valid, exp_pc);
         end
      end
      n_checks++;
      if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL seq_fetch_count: got %0d expected 3", fetch_count); end
   endtask

   task automatic test_branch();
      jump_to(32'h100);
      branch_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
      step();
      branch_taken = 1'b0; exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'hF4) begin n_fail++; $display("FAIL branch_neg: got %h expected 000000f4", pc); end
      jump_to(32'h100);
      branch_taken = 1'b1; br_offset = 32'h20;
      step();
      branch_taken = 1'b0; exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'h124) begin n_fail++; $display("FAIL branch_pos: got %h expected 00000124", pc); end
      n_checks++;
      if (fetch_count !== exp_fc) begin n_fail++; $display("FAIL branch_fetch_count: got %0d expected %0d", fetch_count, exp_fc); end
   endtask

   task automatic test_jump_priority();
      jump_to(32'h40);
      jump_reg = 1'b1; branch_taken = 1'b1; reg_target = 32'h200; br_offset = 32'h8;
      step();
      jump_reg = 1'b0; branch_taken = 1'b0; exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'h200) begin n_fail++; $display("FAIL jump_wins: got %h expected 00000200", pc); end
   endtask

   task automatic test_stall();
      jump_to(32'h80);
      stall = 1'b1; branch_taken = 1'b1; br_offset = 32'h8;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (pc !== 32'h80 || fetch_count !== exp_fc || instr_valid !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got pc=%h fc=%0d v=%b h=%b expected pc=00000080 fc=%0d v=1 h=0", i, pc, fetch_count, instr_valid, halted, exp_fc);
         end
      end
      stall = 1'b0;
      step();
      branch_taken = 1'b0; exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'h8C || fetch_count !== exp_fc) begin
         n_fail++;
         $display("FAIL stall_resume: got pc=%h fc=%0d expected pc=0000008c fc=%0d", pc, fetch_count, exp_fc);
      end
      en = 1'b0;
      step();
      n_checks++;
      if (pc !== 32'h8C) begin n_fail++; $display("FAIL en_low_hold: got %h expected 0000008c", pc); end
      en = 1'b1;
      step();
      exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'h90 || fetch_count !== exp_fc) begin
         n_fail++;
         $display("FAIL en_resume: got pc=%h fc=%0d expected pc=00000090 fc=%0d", pc, fetch_count, exp_fc);
      end
   endtask

   task automatic test_wrap();
      jump_to(32'hFFFF_FFFC);
      n_checks++;
      if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected 00000000", pc_plus4); end
      step();
      exp_fc = exp_fc + 1;
      n_checks++;
      if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", pc); end
   endtask

   task automatic test_halt_with_stall();
      jump_to(32'h60);
      halt_req = 1'b1; stall = 1'b1;
      step();
      halt_req = 1'b0; stall = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h60 || align_err !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_stall: got h=%b v=%b pc=%h a=%b expected h=1 v=0 pc=00000060 a=0", halted, instr_valid, pc, align_err);
      end
      step();
      n_checks++;
      if (halted !== 1'b1 || pc !== 32'h60 || fetch_count !== exp_fc) begin
         n_fail++;
         $display("FAIL halt_terminal: got h=%b pc=%h fc=%0d expected h=1 pc=00000060 fc=%0d", halted, pc, fetch_count, exp_fc);
      end
   endtask

   task automatic test_align();
      do_reset();
      jump_to(32'h10);
      jump_reg = 1'b1; reg_target = 32'h202;
      step();
      jump_reg = 1'b0;
      n_checks++;
      if (pc !== 32'h10 || align_err !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== exp_fc) begin
         n_fail++;
         $display("FAIL align_jump: got pc=%h a=%b h=%b v=%b fc=%0d expected pc=00000010 a=1 h=1 v=0 fc=%0d", pc, align_err, halted, instr_valid, fetch_count, exp_fc);
      end
      jump_to(32'h300);
      exp_fc = exp_fc - 1;
      n_checks++;
      if (pc !== 32'h10 || align_err !== 1'b1 || fetch_count !== exp_fc) begin
         n_fail++;
         $display("FAIL align_ignore: got pc=%h a=%b fc=%0d expected pc=00000010 a=1 fc=%0d", pc, align_err, fetch_count, exp_fc);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (pc !== 32'h0 || align_err !== 1'b0 || halted !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got pc=%h a=%b h=%b v=%b fc=%h expected all zero", pc, align_err, halted, instr_valid, fetch_count);
      end
      do_reset();
      jump_to(32'h20);
      branch_taken = 1'b1; br_offset = 32'h2;
      step();
      branch_taken = 1'b0;
      n_checks++;
      if (pc !== 32'h20 || align_err !== 1'b1 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL align_branch: got pc=%h a=%b h=%b expected pc=00000020 a=1 h=1", pc, align_err, halted);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_stall();
      test_wrap();
      test_halt_with_stall();
      test_align();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
